// File: rtl/lif_neuron_layer.sv
// Time-multiplexed layer of leaky integrate-and-fire neurons.
// One shared sum/leak/threshold datapath visits each neuron in turn after a
// step request. Membranes and refractory counters are kept per neuron. The
// weights sit in a serial shift chain that is loaded while the layer is idle.
module lif_neuron_layer #(
  parameter int INPUTS      = 8,
  parameter int NEURONS     = 4,
  parameter int WEIGHT_BITS = 3,
  parameter int U_BITS      = 8,
  parameter int REFR_BITS   = 3,
  localparam int IDX_W      = $clog2(NEURONS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INPUTS-1:0]      x,
  input  logic                   step,
  input  logic                   w_shift_en,
  input  logic [WEIGHT_BITS-1:0] w_shift_in,
  input  logic [U_BITS-2:0]      threshold,
  input  logic [2:0]             leak_shift,
  input  logic                   reset_mode,
  input  logic [REFR_BITS-1:0]   refractory,
  input  logic [IDX_W-1:0]       probe_sel,
  output logic                   busy,
  output logic                   done,
  output logic [NEURONS-1:0]     spikes,
  output logic [U_BITS-1:0]      probe_u
);

  // Two guard bits are enough for u - leak + sum before saturation.
  localparam int SW = U_BITS + 2;
  localparam logic signed [SW-1:0] U_MAX = SW'((1 << (U_BITS - 1)) - 1);
  localparam logic signed [SW-1:0] U_MIN = ~U_MAX;

  typedef enum logic {IDLE, EVAL} state_t;

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        idx_reg;
  logic [INPUTS-1:0]       x_q_reg;
  logic [NEURONS-1:0]      stage_reg, stage_next;
  logic [NEURONS-1:0]      spikes_reg;
  logic                    done_reg;

  logic [WEIGHT_BITS-1:0]  w_reg [NEURONS][INPUTS];
  logic signed [U_BITS-1:0] u_reg [NEURONS];
  logic [REFR_BITS-1:0]    refr_reg [NEURONS];

  logic                    accept;
  logic                    evaluating;
  logic                    last;
  logic                    shift_ok;

  logic signed [SW-1:0]    psum [INPUTS+1];
  logic signed [U_BITS-1:0] u_cur;
  logic [REFR_BITS-1:0]    refr_cur;
  logic signed [SW-1:0]    u_cur_w, leak_w, u_sum_w, u_int, u_sub, thr_w;
  logic                    fire;
  logic signed [U_BITS-1:0] u_new;
  logic [REFR_BITS-1:0]    refr_new;

  function automatic logic signed [SW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > U_MAX) return U_MAX;
    if (v < U_MIN) return U_MIN;
    return v;
  endfunction

  assign evaluating = (state_reg == EVAL);
  assign accept     = (state_reg == IDLE) && step;
  assign last       = evaluating && (idx_reg == IDX_W'(NEURONS - 1));
  assign shift_ok   = w_shift_en && !evaluating;

  assign busy    = evaluating;
  assign done    = done_reg;
  assign spikes  = spikes_reg;
  assign probe_u = u_reg[probe_sel];

  // Weight chain: entry w[0][0] takes the new value, every other entry takes
  // its flat predecessor, so the oldest value falls off w[NEURONS-1][INPUTS-1].
  for (genvar gj = 0; gj < NEURONS; gj++) begin : g_wn
    for (genvar gi = 0; gi < INPUTS; gi++) begin : g_wi
      logic [WEIGHT_BITS-1:0] prev;
      if (gj == 0 && gi == 0) begin : g_head
        assign prev = w_shift_in;
      end else if (gi == 0) begin : g_wrap
        assign prev = w_reg[gj-1][INPUTS-1];
      end else begin : g_mid
        assign prev = w_reg[gj][gi-1];
      end

      // Shift one chain position when loading is allowed.
      always_ff @(posedge clk) begin
        if (reset) begin
          w_reg[gj][gi] <= '0;
        end else if (shift_ok) begin
          w_reg[gj][gi] <= prev;
        end
      end
    end
  end

  // Running signed sum of the current neuron's weights on active inputs.
  assign psum[0] = '0;
  for (genvar gi = 0; gi < INPUTS; gi++) begin : g_sum
    logic [WEIGHT_BITS-1:0] w_sel;
    assign w_sel = w_reg[idx_reg][gi];
    assign psum[gi+1] = psum[gi] +
      (x_q_reg[gi] ? {{(SW-WEIGHT_BITS){w_sel[WEIGHT_BITS-1]}}, w_sel} : '0);
  end

  assign u_cur    = u_reg[idx_reg];
  assign refr_cur = refr_reg[idx_reg];
  assign u_cur_w  = {{2{u_cur[U_BITS-1]}}, u_cur};
  assign thr_w    = {{(SW-U_BITS+1){1'b0}}, threshold};
  // A shift of zero means no leak; u>>>0 would otherwise erase u entirely.
  assign leak_w   = (leak_shift == 3'd0) ? '0 : (u_cur_w >>> leak_shift);
  assign u_sum_w  = u_cur_w - leak_w + psum[INPUTS];
  assign u_int    = sat(u_sum_w);
  assign u_sub    = sat(u_int - thr_w);

  // Next state plus the membrane/refractory update for the visited neuron.
  always_comb begin
    state_next = state_reg;
    fire       = 1'b0;
    u_new      = u_cur;
    refr_new   = refr_cur;
    stage_next = stage_reg;

    case (state_reg)
      IDLE:    if (step) state_next = EVAL;
      EVAL:    if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (refr_cur != '0) begin
      refr_new = refr_cur - REFR_BITS'(1);
    end else if (u_int >= thr_w) begin
      fire     = 1'b1;
      refr_new = refractory;
      u_new    = reset_mode ? u_sub[U_BITS-1:0] : '0;
    end else begin
      u_new    = u_int[U_BITS-1:0];
    end

    stage_next[idx_reg] = fire;
  end

  // Control state: FSM, neuron index, latched inputs and the spike vectors.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      x_q_reg    <= '0;
      stage_reg  <= '0;
      spikes_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= last;
      if (accept) begin
        x_q_reg   <= x;
        idx_reg   <= '0;
        stage_reg <= '0;
      end else if (evaluating) begin
        stage_reg <= stage_next;
        idx_reg   <= last ? '0 : idx_reg + IDX_W'(1);
        if (last) spikes_reg <= stage_next;
      end
    end
  end

  for (genvar gi = 0; gi < NEURONS; gi++) begin : g_neuron
    // Commit the shared datapath result only into the neuron being visited.
    always_ff @(posedge clk) begin
      if (reset) begin
        u_reg[gi]    <= '0;
        refr_reg[gi] <= '0;
      end else if (evaluating && idx_reg == IDX_W'(gi)) begin
        u_reg[gi]    <= u_new;
        refr_reg[gi] <= refr_new;
      end
    end
  end

endmodule

// File: tb/tb_lif_neuron_layer.sv
// Bench for lif_neuron_layer: a table of timesteps with expected spike vector
// and neuron-0 membrane, checked through a scoreboard queue when done pulses,
// plus hand-written sequences for timing, busy-ignore, back-to-back and abort.
module tb_lif_neuron_layer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] x;
  logic       step;
  logic       w_shift_en;
  logic [2:0] w_shift_in;
  logic [6:0] threshold;
  logic [2:0] leak_shift;
  logic       reset_mode;
  logic [2:0] refractory;
  logic [1:0] probe_sel;
  logic       busy;
  logic       done;
  logic [3:0] spikes;
  logic [7:0] probe_u;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    int         cfg;
    logic [7:0] xv;
    logic [3:0] spk;
    int         u0;
  } vec_t;

  typedef struct {
    logic [3:0] spk;
    int         u0;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  lif_neuron_layer dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .step       (step),
    .w_shift_en (w_shift_en),
    .w_shift_in (w_shift_in),
    .threshold  (threshold),
    .leak_shift (leak_shift),
    .reset_mode (reset_mode),
    .refractory (refractory),
    .probe_sel  (probe_sel),
    .busy       (busy),
    .done       (done),
    .spikes     (spikes),
    .probe_u    (probe_u)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void add(input int c, input logic [7:0] xv,
                              input logic [3:0] s, input int u);
    vecs.push_back('{c, xv, s, u});
  endfunction

  function automatic logic [2:0] weight_of(input int c, input int n, input int i);
    logic [2:0] w;
    w = 3'd0;
    case (c)
      0, 1, 2, 3: w = (n == 0) ? 3'd3 : 3'd0;
      4:          w = (n == 0) ? 3'b100 : 3'd0;
      default: begin
        if (i >= 2) w = 3'b100;
        else case (n)
          0:       w = 3'd3;
          1:       w = 3'b111;
          2:       w = 3'd1;
          default: w = 3'd2;
        endcase
      end
    endcase
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; step = 1'b0; w_shift_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // First value shifted lands in w[3][7], last in w[0][0].
  task automatic load_weights(input int c);
    for (int n = 3; n >= 0; n--) begin
      for (int i = 7; i >= 0; i--) begin
        @(negedge clk);
        w_shift_en = 1'b1;
        w_shift_in = weight_of(c, n, i);
      end
    end
    @(negedge clk);
    w_shift_en = 1'b0;
  endtask

  task automatic set_cfg(input int c);
    threshold  = (c <= 2) ? 7'd20 : (c == 5) ? 7'd4 : 7'd127;
    leak_shift = (c == 3) ? 3'd1 : 3'd0;
    reset_mode = (c == 1);
    refractory = (c == 2) ? 3'd2 : 3'd0;
  endtask

  task automatic setup(input int c);
    do_reset();
    load_weights(c);
    set_cfg(c);
  endtask

  task automatic step_once(input logic [7:0] xv);
    @(negedge clk);
    step = 1'b1; x = xv;
    @(negedge clk);
    step = 1'b0;
  endtask

  // Wait (bounded) for done, then pop the scoreboard and compare.
  task automatic wait_done(input string name);
    exp_t e;
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          check({name, " unexpected done"}, 1, 0);
        end else begin
          e = sb.pop_front();
          check({name, " spikes"}, int'(spikes), int'(e.spk));
          check({name, " u0"}, int'($signed(probe_u)), e.u0);
        end
      end
    end
    if (!seen) begin
      check({name, " done timeout"}, 0, 1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
  endtask

  task automatic probe_all(input string name, input int exp);
    for (int n = 0; n < 4; n++) begin
      probe_sel = 2'(n);
      #1;
      check($sformatf("%s probe_u[%0d]", name, n), int'($signed(probe_u)), exp);
    end
    probe_sel = 2'd0;
  endtask

  initial begin
    int  cur_cfg;
    bit  extra;

    reset = 1'b1; x = '0; step = 1'b0; w_shift_en = 1'b0; w_shift_in = '0;
    threshold = 7'd20; leak_shift = '0; reset_mode = 1'b0; refractory = '0;
    probe_sel = '0;

    add(0, 8'h0F, 4'b0000, 12);  add(0, 8'h0F, 4'b0001, 0);
    add(1, 8'h0F, 4'b0000, 12);  add(1, 8'h0F, 4'b0001, 4);
    add(1, 8'h0F, 4'b0000, 16);
    add(2, 8'h0F, 4'b0000, 12);  add(2, 8'h0F, 4'b0001, 0);
    add(2, 8'h0F, 4'b0000, 0);   add(2, 8'h0F, 4'b0000, 0);
    add(2, 8'h0F, 4'b0000, 12);  add(2, 8'h0F, 4'b0001, 0);
    add(3, 8'hFF, 4'b0000, 24);  add(3, 8'hFF, 4'b0000, 36);
    add(3, 8'hFF, 4'b0000, 42);
    add(4, 8'hFF, 4'b0000, -32); add(4, 8'hFF, 4'b0000, -64);
    add(4, 8'hFF, 4'b0000, -96); add(4, 8'hFF, 4'b0000, -128);
    add(4, 8'hFF, 4'b0000, -128);
    add(5, 8'h03, 4'b1001, 0);   add(5, 8'h03, 4'b1101, 0);
    add(5, 8'h03, 4'b1001, 0);

    // Reset state and exact busy/done timing with all-zero weights.
    do_reset();
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset spikes", int'(spikes), 0);
    x = 8'hFF; step = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      step = 1'b0;
      check($sformatf("timing busy c%0d", c), int'(busy), (c <= 4) ? 1 : 0);
      check($sformatf("timing done c%0d", c), int'(done), (c == 5) ? 1 : 0);
    end
    check("zero-weight spikes", int'(spikes), 0);
    probe_all("zero-weight", 0);

    // Table-driven timesteps.
    cur_cfg = -1;
    for (int v = 0; v < vecs.size(); v++) begin
      if (vecs[v].cfg != cur_cfg) begin
        cur_cfg = vecs[v].cfg;
        setup(cur_cfg);
      end
      sb.push_back('{vecs[v].spk, vecs[v].u0});
      step_once(vecs[v].xv);
      wait_done($sformatf("vec%0d cfg%0d", v, vecs[v].cfg));
    end

    // step, x changes and weight shifts during busy are all ignored.
    setup(0);
    sb.push_back('{4'b0000, 12});
    @(negedge clk);
    step = 1'b1; x = 8'h0F;
    @(negedge clk);
    x = 8'h00; w_shift_en = 1'b1; w_shift_in = 3'b100;
    @(negedge clk);
    @(negedge clk);
    step = 1'b0; w_shift_en = 1'b0;
    wait_done("busy-ignore first");
    extra = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done || busy) extra = 1'b1;
    end
    check("busy-ignore no extra eval", int'(extra), 0);
    sb.push_back('{4'b0001, 0});
    step_once(8'h0F);
    wait_done("busy-ignore weights kept");

    // Step held through the done cycle is accepted immediately.
    setup(0);
    sb.push_back('{4'b0000, 12});
    sb.push_back('{4'b0001, 0});
    @(negedge clk);
    step = 1'b1; x = 8'h0F;
    wait_done("b2b first");
    @(negedge clk);
    step = 1'b0;
    check("b2b accepted in done cycle", int'(busy), 1);
    wait_done("b2b second");

    // Reset in the middle of an evaluation aborts it.
    setup(0);
    step_once(8'h0F);
    @(negedge clk);
    check("abort u0 updated", int'($signed(probe_u)), 12);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    extra = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) extra = 1'b1;
    end
    check("abort no done", int'(extra), 0);
    probe_all("abort", 0);
    sb.push_back('{4'b0000, 0});
    step_once(8'h0F);
    wait_done("abort weights cleared");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
